// File: rtl/pong_button_pio.sv
// pong_button_pio: Avalon-MM button input PIO with sync, debounce, edge capture and maskable irq.
// Define PONG_BUTTON_PIO_DEBOUNCE_EN to build the per-bit debounce counters.
`timescale 1ns/1ps
module pong_button_pio #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CAPTURE_RISING  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d, set_w;
    logic             wr_w;
    logic             unused_w;

    assign unused_w = ^writedata;
    assign wr_w     = chipselect && !write_n;

`ifdef PONG_BUTTON_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]    = '0;
            stable_d[i] = stable_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
                    stable_d[i] = sync2_q[i];
                else
                    cnt_d[i] = CW'(cnt_q[i] + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++)
            cnt_q[i] <= reset ? '0 : cnt_d[i];
    end
`else
    always_comb stable_d = sync2_q;
`endif

    // A set event on the same cycle as a clear wins.
    always_comb begin
        set_w     = (CAPTURE_RISING != 0) ? (~stable_q & stable_d) : (stable_q & ~stable_d);
        irqmask_d = (wr_w && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
        edgecap_d = ((wr_w && address == 2'd3) ? (edgecap_q & ~writedata[WIDTH-1:0]) : edgecap_q) | set_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            stable_q  <= '1;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        readdata = '0;
        readdata[WIDTH-1:0] = (address == 2'd0) ? stable_q :
                              (address == 2'd1) ? sync2_q  :
                              (address == 2'd2) ? irqmask_q : edgecap_q;
    end

    assign irq = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_pong_button_pio.sv
// tb_pong_button_pio: directed self-checking bench for pong_button_pio (WIDTH=2, DEBOUNCE_CYCLES=4).
`timescale 1ns/1ps
module tb_pong_button_pio;
    localparam int D = 4;
`ifdef PONG_BUTTON_PIO_DEBOUNCE_EN
    localparam int LAT = D + 2;
`else
    localparam int LAT = 3;
`endif
    logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
    logic [1:0]  address = '0, in_port = 2'b11;
    logic [31:0] writedata = '0, readdata, v;
    logic        irq;
    int          checks = 0, failures = 0;

    pong_button_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(D), .CAPTURE_RISING(0)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        address = a;
        #1;
        r = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_port = 2'b11;
        repeat (3) tick();
        reset = 1'b0;
        rd(0, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL reset_data got %h want 3", v); end
        rd(1, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL reset_raw got %h want 3", v); end
        rd(2, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_mask got %h want 0", v); end
        rd(3, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_edge got %h want 0", v); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", irq); end
    endtask

    task automatic test_press;
        in_port = 2'b10;
        tick();
        rd(1, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL press_raw_early got %h want 3", v); end
        tick();
        rd(1, v); checks++; if (v !== 32'h2) begin failures++; $display("FAIL press_raw got %h want 2", v); end
        repeat (LAT - 3) tick();
        rd(0, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL press_data_early got %h want 3", v); end
        rd(3, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL press_edge_early got %h want 0", v); end
        tick();
        rd(0, v); checks++; if (v !== 32'h2) begin failures++; $display("FAIL press_data got %h want 2", v); end
        rd(3, v); checks++; if (v !== 32'h1) begin failures++; $display("FAIL press_edge got %h want 1", v); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL press_irq_masked got %b want 0", irq); end
    endtask

    task automatic test_glitch;
`ifdef PONG_BUTTON_PIO_DEBOUNCE_EN
        in_port = 2'b00;
        tick(); tick();
        rd(1, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL glitch_raw got %h want 0", v); end
        tick();
        in_port = 2'b10;
        repeat (8) tick();
        rd(0, v); checks++; if (v !== 32'h2) begin failures++; $display("FAIL glitch_data got %h want 2", v); end
        rd(3, v); checks++; if (v !== 32'h1) begin failures++; $display("FAIL glitch_edge got %h want 1", v); end
`else
        in_port = 2'b00;
        tick();
        in_port = 2'b10;
        tick(); tick();
        rd(0, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL glitch_data got %h want 0", v); end
        rd(3, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL glitch_edge got %h want 3", v); end
        wr(3, 32'h2);
        repeat (3) tick();
        rd(0, v); checks++; if (v !== 32'h2) begin failures++; $display("FAIL glitch_settle got %h want 2", v); end
        rd(3, v); checks++; if (v !== 32'h1) begin failures++; $display("FAIL glitch_clear got %h want 1", v); end
`endif
    endtask

    task automatic test_irq;
        wr(2, 32'h1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_unmask got %b want 1", irq); end
        rd(2, v); checks++; if (v !== 32'h1) begin failures++; $display("FAIL irq_mask_rd got %h want 1", v); end
        wr(3, 32'h1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got %b want 0", irq); end
        rd(3, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL irq_edge_clear got %h want 0", v); end
        in_port = 2'b00;
        repeat (LAT - 1) tick();
        wr(3, 32'h2);
        rd(3, v); checks++; if (v !== 32'h2) begin failures++; $display("FAIL set_wins got %h want 2", v); end
        rd(0, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL set_wins_data got %h want 0", v); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL set_wins_irq got %b want 0", irq); end
    endtask

    task automatic test_release;
        wr(3, 32'h2);
        rd(3, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL release_pre got %h want 0", v); end
        in_port = 2'b11;
        repeat (LAT) tick();
        rd(0, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL release_data got %h want 3", v); end
        rd(3, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL release_edge got %h want 0", v); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL release_irq got %b want 0", irq); end
    endtask

    task automatic test_mask;
        in_port = 2'b10;
        repeat (LAT) tick();
        rd(3, v); checks++; if (v !== 32'h1) begin failures++; $display("FAIL mask_edge got %h want 1", v); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_irq got %b want 1", irq); end
        wr(2, 32'h0);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_off_irq got %b want 0", irq); end
        rd(3, v); checks++; if (v !== 32'h1) begin failures++; $display("FAIL mask_off_edge got %h want 1", v); end
        wr(2, 32'h1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_on_irq got %b want 1", irq); end
    endtask

    task automatic test_reset_mid;
        in_port = 2'b01;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        rd(0, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL mid_data got %h want 3", v); end
        rd(1, v); checks++; if (v !== 32'h3) begin failures++; $display("FAIL mid_raw got %h want 3", v); end
        rd(2, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_mask got %h want 0", v); end
        rd(3, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_edge got %h want 0", v); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq got %b want 0", irq); end
        in_port = 2'b11;
        reset = 1'b0;
        repeat (LAT + 2) tick();
        rd(3, v); checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_after got %h want 0", v); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_irq();
        test_release();
        test_mask();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
